// File: rtl/return_stack_integrity_if.sv
// rtl/return_stack_integrity_if.sv - monitor-side signal bundle for the return shadow stack
interface return_stack_integrity_if #(
   parameter int ADDR_W = 16,
   parameter int SP_W   = 3
);
   logic [ADDR_W-1:0] pc;
   logic [1:0]        ucc_state;
   logic              call_valid;
   logic [ADDR_W-1:0] op_dest;
   logic              outside_ucc;
   logic              reset;
   logic [1:0]        violation_cause;
   logic [SP_W-1:0]   stack_depth;
   logic [ADDR_W-1:0] top_address;

   modport master (
      output pc, ucc_state, call_valid, op_dest, outside_ucc,
      input  reset, violation_cause, stack_depth, top_address
   );

   modport slave (
      input  pc, ucc_state, call_valid, op_dest, outside_ucc,
      output reset, violation_cause, stack_depth, top_address
   );
endinterface

// File: rtl/return_stack_integrity.sv
// rtl/return_stack_integrity.sv - shadow return-address stack guarding exits from untrusted code
module return_stack_integrity #(
   parameter int                ADDR_W        = 16,
   parameter int                DEPTH         = 4,
   parameter int                SP_W          = $clog2(DEPTH + 1),
   parameter logic [ADDR_W-1:0] RESET_HANDLER = '0
) (
   input logic                     clk,
   input logic                     system_reset,
   return_stack_integrity_if.slave mon
);

   typedef enum logic [1:0] {
      NOT_UCC = 2'b00,
      IN_UCC  = 2'b01,
      IRQ     = 2'b10,
      RST     = 2'b11
   } ucc_state_t;

   localparam logic [1:0] CAUSE_NONE      = 2'b00;
   localparam logic [1:0] CAUSE_MISMATCH  = 2'b01;
   localparam logic [1:0] CAUSE_OVERFLOW  = 2'b10;
   localparam logic [1:0] CAUSE_UNDERFLOW = 2'b11;

   // Power-up values match the post-reset state so the system starts held in reset.
   logic [ADDR_W-1:0] stack_mem [DEPTH] = '{default: '0};
   logic [SP_W-1:0]   sp      = '0;
   logic              reset_q = 1'b1;
   logic [1:0]        cause_q = CAUSE_NONE;

   ucc_state_t        state;
   logic [ADDR_W-1:0] top;
   logic              ret_check, underflow, mismatch, valid_ret;
   logic              rst_release, push_req, overflow, violation;
   logic [1:0]        cause_nxt;
   logic [SP_W-1:0]   sp_nxt, wr_idx;
   logic              wr_en;

   assign state = ucc_state_t'(mon.ucc_state);

   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp == SP_W'(i + 1)) top = stack_mem[i];
      end
   end

   always_comb begin
      ret_check   = (state == IN_UCC) && mon.outside_ucc;
      underflow   = ret_check && (sp == '0);
      mismatch    = ret_check && (sp != '0) && (mon.pc != top);
      valid_ret   = ret_check && (sp != '0) && (mon.pc == top);
      rst_release = (state == RST) && (mon.pc == RESET_HANDLER);
      push_req    = mon.call_valid &&
                    ((state == NOT_UCC) || (state == IN_UCC) || rst_release);
      // A failed return check discards the push, so overflow only stands alone.
      overflow    = push_req && !valid_ret && !underflow && !mismatch &&
                    (sp == SP_W'(DEPTH));
      violation   = underflow || mismatch || overflow;

      cause_nxt = CAUSE_NONE;
      if (underflow)     cause_nxt = CAUSE_UNDERFLOW;
      else if (mismatch) cause_nxt = CAUSE_MISMATCH;
      else if (overflow) cause_nxt = CAUSE_OVERFLOW;
   end

   always_comb begin
      sp_nxt = sp;
      wr_en  = 1'b0;
      wr_idx = sp;
      if (violation) begin
         sp_nxt = '0;
      end else begin
         case (state)
            RST: begin
               sp_nxt = '0;
               if (push_req) begin
                  wr_en  = 1'b1;
                  wr_idx = '0;
                  sp_nxt = SP_W'(1);
               end
            end
            IRQ: sp_nxt = sp;
            default: begin
               // Merged pop+push replaces the top slot in place.
               if (valid_ret && push_req) begin
                  wr_en  = 1'b1;
                  wr_idx = sp - SP_W'(1);
               end else if (valid_ret) begin
                  sp_nxt = sp - SP_W'(1);
               end else if (push_req) begin
                  wr_en  = 1'b1;
                  wr_idx = sp;
                  sp_nxt = sp + SP_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (system_reset) begin
         sp      <= '0;
         reset_q <= 1'b1;
         cause_q <= CAUSE_NONE;
         for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
      end else begin
         sp      <= sp_nxt;
         reset_q <= violation || ((state == RST) && (mon.pc != RESET_HANDLER));
         if (violation && (cause_q == CAUSE_NONE)) cause_q <= cause_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_idx == SP_W'(i))) stack_mem[i] <= mon.op_dest;
         end
      end
   end

   assign mon.reset           = reset_q;
   assign mon.violation_cause = cause_q;
   assign mon.stack_depth     = sp;
   assign mon.top_address     = top;

endmodule

// File: doc/return_stack_integrity.md
Name: return_stack_integrity

Overview:
- Parametrised successor to the single-register return-address monitor, used inside the UCC hardware monitor.
- Keeps a hardware shadow stack of return addresses so nested and repeated calls into untrusted code (UCC) are protected, not just one outstanding call.
- Every exit from UCC is checked against the top of the shadow stack.
- Any violation (mismatch, overflow, underflow) raises a registered reset request to the system reset logic.

Parameters:
- ADDR_W, 16, width of pc, op_dest and stored return addresses.
- DEPTH, 4, number of shadow-stack entries (>=1).
- SP_W, $clog2(DEPTH+1), width of the stack-depth counter.
- RESET_HANDLER, 16'h0000 (ADDR_W bits), address the pc must reach before reset is released.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- system_reset  input  1  synchronous, active-high reset; also the system-wide reset indication.
- pc  input  ADDR_W  current program counter.
- ucc_state  input  2  monitor state: 00 notUCC, 01 inUCC, 10 IRQ, 11 RST.
- call_valid  input  1  one-cycle pulse: control transfer into UCC this cycle.
- op_dest  input  ADDR_W  return address to push when call_valid=1.
- outside_ucc  input  1  pc is leaving/outside UCC this cycle (return point).
- reset  output  1  registered reset request.
- violation_cause  output  2  sticky cause: 00 none, 01 mismatch, 10 overflow, 11 underflow.
- stack_depth  output  SP_W  current number of valid entries (formal/debug).
- top_address  output  ADDR_W  entry at sp-1; 0 when empty (formal/debug).

Behaviour:
- system_reset=1 (any state):
  - next cycle: sp=0, all entries 0, violation_cause=00, reset=1.
  - reset stays 1 while system_reset is held.
- Power-up initial values: reset=1, sp=0, entries 0.
- Return check, evaluated only when ucc_state=inUCC && outside_ucc:
  - sp==0 → underflow violation.
  - else pc!=top_address → mismatch violation.
  - else valid return → pop (sp-1).
- Push: call_valid=1 in notUCC or inUCC with no violation this cycle.
  - sp<DEPTH → write op_dest at index sp, sp+1.
  - sp==DEPTH → overflow violation, no write.
- Simultaneous valid return and call_valid: the pop and push merge. The top slot is overwritten with op_dest and sp is unchanged.
  - If the return check fails, the push is discarded.
- Violation:
  - reset=1 on the next edge (1-cycle latency).
  - sp cleared to 0.
  - violation_cause latched. Cause stays sticky until system_reset; only the first cause is recorded.
- IRQ state: stack frozen; call_valid and outside_ucc ignored; reset=0 unless system_reset.
- RST state:
  - sp held at 0, pushes ignored.
  - reset=1 each cycle pc!=RESET_HANDLER.
  - reset=0 once pc==RESET_HANDLER and system_reset=0.
  - A call_valid arriving in the same cycle as the pc==RESET_HANDLER release is pushed.
- notUCC with outside_ucc and no call: no stack change, no check.
- reset output formula (registered):
  - system_reset, or violation this cycle, or (ucc_state==RST && pc!=RESET_HANDLER).
  - Otherwise 0.
- sp never exceeds DEPTH and never wraps below 0.
- top_address is combinational from the stack array and sp.

Test Plan:
1. Nested calls (DEPTH=4): push 0x1004, 0x2008, 0x300C; exit with pc=0x300C, then 0x2008, then 0x1004 → sp goes 3,2,1,0; reset stays 0; cause=00.
2. Mismatch: push 0x1004; inUCC exit with pc=0x1234 → reset=1 one cycle later; violation_cause=01; stack_depth=0.
3. Overflow: push 4 entries, then a 5th call_valid op_dest=0x5000 → reset=1 next cycle; violation_cause=10; entries not written; sp=0.
4. Underflow: sp=0, inUCC, outside_ucc=1, pc=0x0040 → reset=1; violation_cause=11.
5. Simultaneous pop+push: top=0x1004, pc=0x1004 with outside_ucc=1 and call_valid=1, op_dest=0x6000 → sp unchanged; top_address=0x6000; reset=0.
6. Reset mid-operation and IRQ:
   - sp=3, assert system_reset 2 cycles → sp=0, cause=00, reset=1 during both cycles.
   - In RST with pc=0x0010 → reset=1; pc=0x0000 → reset=0 next cycle.
   - IRQ with outside_ucc=1 → sp unchanged.
